rf_multiport: RTL and testbench

- Parametrised successor to the single-cycle CPU register file.
- Generalised in data width, depth and read-port count.
- Adds a dedicated link-write port for jal/jalr, so link writes no longer need instruction decoding inside the register file.
- Adds optional write-to-read bypass and a per-register pending scoreboard.
- Sits between decode (read addresses, scoreboard set) and writeback (main and link writes) in single-cycle and future pipelined datapaths.

---
 rtl/rf_pkg.sv | 27 ++
 rtl/rf_read_port.sv | 61 ++++++
 rtl/rf_multiport.sv | 99 +++++++++
 tb/tb_rf_multiport.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and helpers for the multiport register file.
//   RF_DW_DEF        default data width
//   RF_NREG_DEF      default register count
//   RF_LINK_REG_DEF  default link register index (top register)
//   rf_slice()       extracts field idx of width w from a packed port vector
package rf_pkg;

    localparam int RF_DW_DEF       = 32;
    localparam int RF_NREG_DEF     = 32;
    localparam int RF_LINK_REG_DEF = RF_NREG_DEF - 32'sd1;

    // Upper bounds for the generic slice helper; callers zero-extend into
    // RF_VEC_MAX bits and narrow the RF_SLICE_MAX-bit result with a cast.
    localparam int RF_VEC_MAX   = 256;
    localparam int RF_SLICE_MAX = 64;

    function automatic logic [RF_SLICE_MAX-1:0] rf_slice(
        input logic [RF_VEC_MAX-1:0] vec,
        input int                    idx,
        input int                    w
    );
        logic [RF_SLICE_MAX-1:0] mask_s;
        mask_s = ~({RF_SLICE_MAX{1'b1}} << w);
        return RF_SLICE_MAX'(vec >> (idx * w)) & mask_s;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of the register file.
//   rd_addr            register index read by this port
//   regs, pending      stored register contents and scoreboard bits
//   wr_en/wr_addr/wr_data, lnk_en/lnk_data
//                      writes landing at the coming edge (bypass sources);
//                      enables are already qualified by reset in the top
//   sb_set/sb_addr     scoreboard set landing at the coming edge
//   rd_data, rd_busy   read value and pending flag for rd_addr
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW_DEF,
    parameter int NREG     = RF_NREG_DEF,
    parameter int AW       = $clog2(NREG),
    parameter int LINK_REG = RF_LINK_REG_DEF,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]            rd_addr,
    input  logic [NREG-1:0][DW-1:0]  regs,
    input  logic [NREG-1:0]          pending,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     lnk_en,
    input  logic [DW-1:0]            lnk_data,
    input  logic                     sb_set,
    input  logic [AW-1:0]            sb_addr,
    output logic [DW-1:0]            rd_data,
    output logic                     rd_busy
);

    localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};
    localparam logic          BYP_ON   = (BYPASS != 32'sd0);

    logic wr_hit_s;
    logic lnk_hit_s;
    logic set_hit_s;

    // Read mux with register-0 forcing, link-wins bypass and busy masking.
    always_comb begin
        wr_hit_s  = wr_en  && (wr_addr == rd_addr);
        lnk_hit_s = lnk_en && (LINK_IDX == rd_addr);
        set_hit_s = sb_set && (sb_addr == rd_addr);
        rd_data   = regs[rd_addr];
        rd_busy   = pending[rd_addr];
        if (rd_addr == ZERO_IDX) begin
            rd_data = {DW{1'b0}};
            rd_busy = 1'b0;
        end else if (BYP_ON && (lnk_hit_s || wr_hit_s)) begin
            rd_data = lnk_hit_s ? lnk_data : wr_data;
            // A producer retiring this cycle is no longer outstanding unless
            // a new producer claims the same register at the same edge.
            rd_busy = set_hit_s ? pending[rd_addr] : 1'b0;
        end else begin
            rd_data = regs[rd_addr];
            rd_busy = pending[rd_addr];
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: parametrised register file with NRD read ports, a main write
// port, a dedicated link write port and a per-register pending scoreboard.
//   clk, rst_n          clock, asynchronous active-low reset
//   rd_addr/rd_data     NRD packed read indices / read data
//   rd_busy             per read port, 1 = addressed register has a producer
//   wr_en/wr_addr/wr_data   main write port
//   lnk_en/lnk_data     link write port (always targets LINK_REG, wins ties)
//   sb_set/sb_addr      mark a register pending at the next edge
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW_DEF,
    parameter int NREG     = RF_NREG_DEF,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int LINK_REG = NREG - (RF_NREG_DEF - RF_LINK_REG_DEF),
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*DW-1:0]   rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                lnk_en,
    input  logic [DW-1:0]       lnk_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr
);

    localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

    logic [NREG-1:0][DW-1:0] regs_r;
    logic [NREG-1:0]         pending_r;
    logic [RF_VEC_MAX-1:0]   rd_addr_ext_s;
    logic                    wr_act_s;
    logic                    lnk_act_s;
    logic                    set_act_s;

    // While reset is held the outputs must read as zero, so incoming writes
    // are hidden from the bypass path as well as from the array.
    assign wr_act_s  = wr_en  && rst_n && (wr_addr != ZERO_IDX);
    assign lnk_act_s = lnk_en && rst_n && (LINK_IDX != ZERO_IDX);
    assign set_act_s = sb_set && rst_n && (sb_addr != ZERO_IDX);

    assign rd_addr_ext_s = {{(RF_VEC_MAX - NRD*AW){1'b0}}, rd_addr};

    // Storage and scoreboard update; link after main so link wins, set after
    // clear so a new producer supersedes the retiring one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_r    <= {(NREG*DW){1'b0}};
            pending_r <= {NREG{1'b0}};
        end else begin
            if (wr_act_s) begin
                regs_r[wr_addr]    <= wr_data;
                pending_r[wr_addr] <= 1'b0;
            end
            if (lnk_act_s) begin
                regs_r[LINK_IDX]    <= lnk_data;
                pending_r[LINK_IDX] <= 1'b0;
            end
            if (set_act_s) begin
                pending_r[sb_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] port_addr_s;

        assign port_addr_s = AW'(rf_slice(rd_addr_ext_s, i, AW));

        rf_read_port #(
            .DW       (DW),
            .NREG     (NREG),
            .AW       (AW),
            .LINK_REG (LINK_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .rd_addr  (port_addr_s),
            .regs     (regs_r),
            .pending  (pending_r),
            .wr_en    (wr_act_s),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .lnk_en   (lnk_act_s),
            .lnk_data (lnk_data),
            .sb_set   (set_act_s),
            .sb_addr  (sb_addr),
            .rd_data  (rd_data[i*DW +: DW]),
            .rd_busy  (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: drives a bypassing and a non-bypassing three-port register
// file with the same stimulus and compares both against a register-array model.
module tb_rf_multiport;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 3;
    localparam int LREG = 31;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     ra [NRD];
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data_b;
    logic [NRD*DW-1:0] rd_data_n;
    logic [NRD-1:0]    rd_busy_b;
    logic [NRD-1:0]    rd_busy_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              lnk_en;
    logic [DW-1:0]     lnk_data;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;

    logic [DW-1:0] mem  [NREG];
    bit            pend [NREG];
    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    int            fail_cnt = 0;

    always #5 clk = ~clk;

    assign rd_addr = {ra[2], ra[1], ra[0]};

    rf_multiport #(.DW(DW), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lnk_en(lnk_en), .lnk_data(lnk_data), .sb_set(sb_set), .sb_addr(sb_addr)
    );

    rf_multiport #(.DW(DW), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lnk_en(lnk_en), .lnk_data(lnk_data), .sb_set(sb_set), .sb_addr(sb_addr)
    );

    function automatic logic [DW-1:0] exp_data(input int a, input bit byp);
        if (!rst_n || a == 0) return 32'h0000_0000;
        if (byp && lnk_en && a == LREG) return lnk_data;
        if (byp && wr_en && a == int'(wr_addr)) return wr_data;
        return mem[a];
    endfunction

    function automatic bit exp_busy(input int a, input bit byp);
        bit written;
        if (!rst_n || a == 0) return 1'b0;
        written = (lnk_en && a == LREG) || (wr_en && a == int'(wr_addr));
        if (byp && written && !(sb_set && a == int'(sb_addr))) return 1'b0;
        return pend[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("%s byp p%0d data", tag, p), rd_data_b[p*DW +: DW], exp_data(int'(ra[p]), 1'b1));
            check($sformatf("%s nobyp p%0d data", tag, p), rd_data_n[p*DW +: DW], exp_data(int'(ra[p]), 1'b0));
            check($sformatf("%s byp p%0d busy", tag, p), 32'(rd_busy_b[p]), 32'(exp_busy(int'(ra[p]), 1'b1)));
            check($sformatf("%s nobyp p%0d busy", tag, p), 32'(rd_busy_n[p]), 32'(exp_busy(int'(ra[p]), 1'b0)));
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            mem[r]  = 32'h0000_0000;
            pend[r] = 1'b0;
        end
    endtask

    // Check outputs mid-cycle, then let one edge happen and advance the model.
    task automatic cyc(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                mem[wr_addr]  = wr_data;
                pend[wr_addr] = 1'b0;
            end
            if (lnk_en) begin
                mem[LREG]  = lnk_data;
                pend[LREG] = 1'b0;
            end
            if (sb_set && sb_addr != 5'd0) pend[sb_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        lnk_en = 1'b0;
        sb_set = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
    endtask

    task automatic rd(input int a0, input int a1, input int a2);
        ra[0] = AW'(a0);
        ra[1] = AW'(a1);
        ra[2] = AW'(a2);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'h0;
        lnk_data = 32'h0;
        sb_addr  = 5'd0;
        idle();
        rd(5, 31, 9);
        model_clear();
        @(negedge clk);
        cyc("reset");
        rst_n = 1'b1;

        // basic write / read-back
        wr(5, 32'hDEAD_BEEF); rd(5, 1, 2);
        cyc("wr5");
        idle();
        cyc("rd5");
        // register 0 ignores writes
        wr(0, 32'h0000_1234); rd(0, 5, 0);
        cyc("wr0");
        idle();
        cyc("rd0");

        // link conflict on LINK_REG, then separate targets
        wr(31, 32'hAAAA_0000); lnk_en = 1'b1; lnk_data = 32'h0040_0008; rd(31, 5, 0);
        cyc("lnk_conf");
        idle();
        cyc("lnk_conf_rd");
        wr(7, 32'hAAAA_0000); lnk_en = 1'b1; lnk_data = 32'h0040_0010; rd(7, 31, 0);
        cyc("lnk_sep");
        idle();
        cyc("lnk_sep_rd");

        // same-cycle bypass vs next-cycle visibility
        wr(3, 32'h0000_0055); rd(0, 3, 5);
        cyc("byp3");
        idle();
        cyc("byp3_rd");

        // scoreboard set, clear by write, simultaneous set and write
        sb_set = 1'b1; sb_addr = 5'd9; rd(9, 0, 3);
        cyc("sb_set");
        idle();
        cyc("sb_busy");
        wr(9, 32'h0000_0099);
        cyc("sb_clr");
        idle();
        cyc("sb_cleared");
        sb_set = 1'b1; sb_addr = 5'd9; wr(9, 32'h0000_0100);
        cyc("sb_setwr");
        idle();
        cyc("sb_setwr_rd");
        lnk_en = 1'b1; lnk_data = 32'h0040_0020; sb_set = 1'b1; sb_addr = 5'd31; rd(31, 9, 0);
        cyc("sb_lnk_set");
        idle();
        cyc("sb_lnk_rd");

        // three ports on distinct registers, one of them on register 0
        wr(10, 32'd1); cyc("mp_w10");
        wr(11, 32'd2); cyc("mp_w11");
        wr(12, 32'd3); cyc("mp_w12");
        idle();
        rd(10, 11, 12);
        cyc("mp_rd");
        rd(10, 0, 12);
        cyc("mp_rd0");

        // reset asserted mid-cycle with a write pending
        wr(5, 32'h7777_7777); rd(5, 31, 9);
        #2;
        rst_n = 1'b0;
        model_clear();
        cyc("rst_mid");
        rst_n = 1'b1;
        idle();
        cyc("rst_after");

        // randomized traffic concentrated on a few registers
        for (int n = 0; n < 300; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'(($urandom_range(0, 3) == 0) ? 31 : $urandom_range(0, 7));
            wr_data  = $urandom;
            lnk_en   = 1'($urandom_range(0, 3) == 0);
            lnk_data = $urandom;
            sb_set   = 1'($urandom_range(0, 1));
            sb_addr  = AW'(($urandom_range(0, 3) == 0) ? 31 : $urandom_range(0, 7));
            for (int p = 0; p < NRD; p++) begin
                ra[p] = AW'(($urandom_range(0, 3) == 0) ? 31 : $urandom_range(0, 7));
            end
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst_n = 1'b0;
                model_clear();
                cyc("rand_rst");
                rst_n = 1'b1;
            end else begin
                cyc("rand");
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
